key_debounce_conditioner: RTL and testbench

//  Conditions the raw DE1-SoC push-buttons (KEY[3:0], active-low, bouncy, asynchronous)

---
 rtl/key_debounce_conditioner.sv | 152 +++++++++++++++
 tb/tb_key_debounce_conditioner.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce_conditioner.sv
// Per-key conditioning of the raw active-low board push-buttons: two-flop synchroniser,
// debounce FSM, and registered one-cycle press / release / long-press pulses.
module key_debounce_conditioner #(
   parameter int NUM_KEYS          = 4,
   parameter int DEBOUNCE_CYCLES   = 1_000_000,
   parameter int LONG_PRESS_CYCLES = 50_000_000
) (
   input  logic                clk_clk,
   input  logic                reset_reset,
   input  logic [NUM_KEYS-1:0] key_raw_n,
   output logic [NUM_KEYS-1:0] key_level_n,
   output logic [NUM_KEYS-1:0] key_press_pulse,
   output logic [NUM_KEYS-1:0] key_release_pulse,
   output logic [NUM_KEYS-1:0] key_long_pulse
);

   localparam int CW = $clog2(LONG_PRESS_CYCLES + 1);
   localparam logic [CW-1:0] CNT_ONE     = CW'(1);
   localparam logic [CW-1:0] DEB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_PRESS_CYCLES - 1);
   localparam logic [CW-1:0] LONG_SAT    = CW'(LONG_PRESS_CYCLES);
   // A one-cycle debounce window accepts a change straight from the stable state.
   localparam bit            ACCEPT_NOW  = (DEBOUNCE_CYCLES == 1);

   typedef enum logic [1:0] {
      ST_UP      = 2'd0,
      ST_WAIT_DN = 2'd1,
      ST_DOWN    = 2'd2,
      ST_WAIT_UP = 2'd3
   } key_state_e;

   key_state_e          state_q [NUM_KEYS];
   key_state_e          state_d [NUM_KEYS];
   logic [CW-1:0]       cnt_q   [NUM_KEYS];
   logic [CW-1:0]       cnt_d   [NUM_KEYS];
   logic [NUM_KEYS-1:0] sync1_q, sync1_d;
   logic [NUM_KEYS-1:0] sync2_q, sync2_d;
   logic [NUM_KEYS-1:0] level_n_q, level_n_d;
   logic [NUM_KEYS-1:0] press_q, press_d;
   logic [NUM_KEYS-1:0] release_q, release_d;
   logic [NUM_KEYS-1:0] long_q, long_d;

   always_comb begin
      sync1_d   = key_raw_n;
      sync2_d   = sync1_q;
      level_n_d = level_n_q;
      press_d   = '0;
      release_d = '0;
      long_d    = '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         // sync2_q is active-low: 0 means the key is currently pressed.
         case (state_q[i])
            ST_UP: begin
               if (!sync2_q[i]) begin
                  if (ACCEPT_NOW) begin
                     state_d[i]   = ST_DOWN;
                     cnt_d[i]     = '0;
                     level_n_d[i] = 1'b0;
                     press_d[i]   = 1'b1;
                  end else begin
                     state_d[i] = ST_WAIT_DN;
                     cnt_d[i]   = CNT_ONE;
                  end
               end else begin
                  cnt_d[i] = '0;
               end
            end
            ST_WAIT_DN: begin
               if (sync2_q[i]) begin
                  state_d[i] = ST_UP;
                  cnt_d[i]   = '0;
               end else if (cnt_q[i] == DEB_LAST) begin
                  state_d[i]   = ST_DOWN;
                  cnt_d[i]     = '0;
                  level_n_d[i] = 1'b0;
                  press_d[i]   = 1'b1;
               end else begin
                  cnt_d[i] = cnt_q[i] + CNT_ONE;
               end
            end
            ST_DOWN: begin
               if (sync2_q[i]) begin
                  if (ACCEPT_NOW) begin
                     state_d[i]   = ST_UP;
                     cnt_d[i]     = '0;
                     level_n_d[i] = 1'b1;
                     release_d[i] = 1'b1;
                  end else begin
                     state_d[i] = ST_WAIT_UP;
                     cnt_d[i]   = CNT_ONE;
                  end
               end else begin
                  // Saturating hold timer guarantees a single long pulse per press.
                  if (cnt_q[i] != LONG_SAT) cnt_d[i] = cnt_q[i] + CNT_ONE;
                  if (cnt_q[i] == LONG_LAST) long_d[i] = 1'b1;
               end
            end
            ST_WAIT_UP: begin
               if (!sync2_q[i]) begin
                  state_d[i] = ST_DOWN;
                  cnt_d[i]   = '0;
               end else if (cnt_q[i] == DEB_LAST) begin
                  state_d[i]   = ST_UP;
                  cnt_d[i]     = '0;
                  level_n_d[i] = 1'b1;
                  release_d[i] = 1'b1;
               end else begin
                  cnt_d[i] = cnt_q[i] + CNT_ONE;
               end
            end
            default: begin
               state_d[i] = ST_UP;
               cnt_d[i]   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         sync1_q   <= '1;
         sync2_q   <= '1;
         level_n_q <= '1;
         press_q   <= '0;
         release_q <= '0;
         long_q    <= '0;
         for (int i = 0; i < NUM_KEYS; i++) begin
            state_q[i] <= ST_UP;
            cnt_q[i]   <= '0;
         end
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         level_n_q <= level_n_d;
         press_q   <= press_d;
         release_q <= release_d;
         long_q    <= long_d;
         for (int i = 0; i < NUM_KEYS; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
      end
   end

   assign key_level_n       = level_n_q;
   assign key_press_pulse   = press_q;
   assign key_release_pulse = release_q;
   assign key_long_pulse    = long_q;

endmodule

// File: tb/tb_key_debounce_conditioner.sv
// Directed bench for key_debounce_conditioner with short debounce/long-press windows.
module tb_key_debounce_conditioner;

   localparam int NK = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NK-1:0] raw_n = '1;
   logic [NK-1:0] level_n, press, release_p, long_p;

   int checks = 0;
   int errors = 0;

   key_debounce_conditioner #(
      .NUM_KEYS(NK),
      .DEBOUNCE_CYCLES(8),
      .LONG_PRESS_CYCLES(32)
   ) dut (
      .clk_clk(clk),
      .reset_reset(rst),
      .key_raw_n(raw_n),
      .key_level_n(level_n),
      .key_press_pulse(press),
      .key_release_pulse(release_p),
      .key_long_pulse(long_p)
   );

   always #5 clk = ~clk;

   // Advance one edge and land 1 ns after it for sampling and driving.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [4*NK-1:0] exp;
      rst   = 1'b1;
      raw_n = '1;
      exp   = {4'hF, 4'h0, 4'h0, 4'h0};
      for (int i = 1; i <= 3; i++) begin
         tick();
         checks++;
         if ({level_n, press, release_p, long_p} !== exp) begin
            errors++;
            $display("FAIL reset_hold cyc %0d got %h exp %h", i, {level_n, press, release_p, long_p}, exp);
         end
      end
      rst = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         tick();
         checks++;
         if ({level_n, press, release_p, long_p} !== exp) begin
            errors++;
            $display("FAIL reset_after cyc %0d got %h exp %h", i, {level_n, press, release_p, long_p}, exp);
         end
      end
   endtask

   task automatic test_press();
      logic [4*NK-1:0] exp;
      raw_n = 4'hE;
      for (int i = 1; i <= 20; i++) begin
         tick();
         exp = {(i >= 10) ? 4'hE : 4'hF, (i == 10) ? 4'h1 : 4'h0, 4'h0, 4'h0};
         checks++;
         if ({level_n, press, release_p, long_p} !== exp) begin
            errors++;
            $display("FAIL press_key0 cyc %0d got %h exp %h", i, {level_n, press, release_p, long_p}, exp);
         end
      end
      raw_n = 4'hF;
      for (int i = 1; i <= 12; i++) begin
         tick();
         exp = {(i >= 10) ? 4'hF : 4'hE, 4'h0, (i == 10) ? 4'h1 : 4'h0, 4'h0};
         checks++;
         if ({level_n, press, release_p, long_p} !== exp) begin
            errors++;
            $display("FAIL release_key0 cyc %0d got %h exp %h", i, {level_n, press, release_p, long_p}, exp);
         end
      end
   endtask

   task automatic test_bounce();
      logic [4*NK-1:0] exp;
      exp = {4'hF, 4'h0, 4'h0, 4'h0};
      for (int i = 0; i < 42; i++) begin
         raw_n[1] = (i >= 30) ? 1'b1 : (((i / 3) % 2) != 0);
         tick();
         checks++;
         if ({level_n, press, release_p, long_p} !== exp) begin
            errors++;
            $display("FAIL bounce_key1 cyc %0d got %h exp %h", i, {level_n, press, release_p, long_p}, exp);
         end
      end
   endtask

   task automatic test_long_press();
      logic [4*NK-1:0] exp;
      raw_n = 4'hB;
      for (int i = 1; i <= 50; i++) begin
         tick();
         exp = {(i >= 10) ? 4'hB : 4'hF, (i == 10) ? 4'h4 : 4'h0, 4'h0, (i == 42) ? 4'h4 : 4'h0};
         checks++;
         if ({level_n, press, release_p, long_p} !== exp) begin
            errors++;
            $display("FAIL long_hold_key2 cyc %0d got %h exp %h", i, {level_n, press, release_p, long_p}, exp);
         end
      end
      raw_n = 4'hF;
      for (int i = 1; i <= 12; i++) begin
         tick();
         exp = {(i >= 10) ? 4'hF : 4'hB, 4'h0, (i == 10) ? 4'h4 : 4'h0, 4'h0};
         checks++;
         if ({level_n, press, release_p, long_p} !== exp) begin
            errors++;
            $display("FAIL long_release_key2 cyc %0d got %h exp %h", i, {level_n, press, release_p, long_p}, exp);
         end
      end
   endtask

   task automatic test_all_keys();
      logic [4*NK-1:0] exp;
      raw_n = 4'h0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         exp = {(i >= 10) ? 4'h0 : 4'hF, (i == 10) ? 4'hF : 4'h0, 4'h0, 4'h0};
         checks++;
         if ({level_n, press, release_p, long_p} !== exp) begin
            errors++;
            $display("FAIL all_press cyc %0d got %h exp %h", i, {level_n, press, release_p, long_p}, exp);
         end
      end
      raw_n = 4'h8;
      for (int i = 1; i <= 10; i++) begin
         tick();
         exp = {(i >= 10) ? 4'h8 : 4'h0, 4'h0, (i == 10) ? 4'h8 : 4'h0, 4'h0};
         checks++;
         if ({level_n, press, release_p, long_p} !== exp) begin
            errors++;
            $display("FAIL key3_release cyc %0d got %h exp %h", i, {level_n, press, release_p, long_p}, exp);
         end
      end
      raw_n = 4'hF;
      for (int i = 1; i <= 12; i++) begin
         tick();
         exp = {(i >= 10) ? 4'hF : 4'h8, 4'h0, (i == 10) ? 4'h7 : 4'h0, 4'h0};
         checks++;
         if ({level_n, press, release_p, long_p} !== exp) begin
            errors++;
            $display("FAIL rest_release cyc %0d got %h exp %h", i, {level_n, press, release_p, long_p}, exp);
         end
      end
   endtask

   task automatic test_reset_mid_hold();
      logic [4*NK-1:0] exp;
      raw_n = 4'hE;
      for (int i = 1; i <= 14; i++) begin
         tick();
         exp = {(i >= 10) ? 4'hE : 4'hF, (i == 10) ? 4'h1 : 4'h0, 4'h0, 4'h0};
         checks++;
         if ({level_n, press, release_p, long_p} !== exp) begin
            errors++;
            $display("FAIL pre_reset_press cyc %0d got %h exp %h", i, {level_n, press, release_p, long_p}, exp);
         end
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp = {4'hF, 4'h0, 4'h0, 4'h0};
      checks++;
      if ({level_n, press, release_p, long_p} !== exp) begin
         errors++;
         $display("FAIL mid_hold_reset got %h exp %h", {level_n, press, release_p, long_p}, exp);
      end
      for (int i = 1; i <= 12; i++) begin
         tick();
         exp = {(i >= 10) ? 4'hE : 4'hF, (i == 10) ? 4'h1 : 4'h0, 4'h0, 4'h0};
         checks++;
         if ({level_n, press, release_p, long_p} !== exp) begin
            errors++;
            $display("FAIL redetect_press cyc %0d got %h exp %h", i, {level_n, press, release_p, long_p}, exp);
         end
      end
      raw_n = 4'hF;
      for (int i = 1; i <= 12; i++) begin
         tick();
         exp = {(i >= 10) ? 4'hF : 4'hE, 4'h0, (i == 10) ? 4'h1 : 4'h0, 4'h0};
         checks++;
         if ({level_n, press, release_p, long_p} !== exp) begin
            errors++;
            $display("FAIL redetect_release cyc %0d got %h exp %h", i, {level_n, press, release_p, long_p}, exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_press();
      test_bounce();
      test_long_press();
      test_all_keys();
      test_reset_mid_hold();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired before end of sequence");
      $fatal(1, "watchdog");
   end

endmodule
